// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer.
//   alarm_state_t : controller states IDLE / RING / SNOOZE
//   DAY_SAT/SUN   : day-of-week codes treated as the weekend
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

  localparam logic [2:0] DAY_SAT = 3'd5;
  localparam logic [2:0] DAY_SUN = 3'd6;

endpackage

// File: rtl/alarm_sequencer_if.sv
// Bus between the clock/alarm datapath and the alarm sequencer.
//   Inputs to the sequencer : tick, match, alarm_on, snooze, day[2:0]
//   Outputs of the sequencer: buzz, ringing, snoozing, snooze_left
//   master modport: stimulus side (datapath / bench)
//   slave  modport: alarm_sequencer
interface alarm_sequencer_if #(
  parameter int MAX_SNOOZE = 3
);
  localparam int SL_W = $clog2(MAX_SNOOZE + 1);

  logic            tick;
  logic            match;
  logic            alarm_on;
  logic            snooze;
  logic [2:0]      day;
  logic            buzz;
  logic            ringing;
  logic            snoozing;
  logic [SL_W-1:0] snooze_left;

  modport master (
    output tick, match, alarm_on, snooze, day,
    input  buzz, ringing, snoozing, snooze_left
  );

  modport slave (
    input  tick, match, alarm_on, snooze, day,
    output buzz, ringing, snoozing, snooze_left
  );

endinterface

// File: rtl/alarm_sequencer_rise_det.sv
// Rising-edge detector used for the match and snooze levels.
//   clk  : system clock
//   rst  : asynchronous active-low reset (clears the history flop)
//   d    : level input, synchronous to clk
//   rise : high for the cycle in which d is 1 and was 0 on the previous cycle
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= 1'b0;
    else      r_q <= d;
  end

  assign rise = d & ~r_q;

endmodule

// File: rtl/alarm_sequencer.sv
// Alarm sequencer: turns the time==alarm match and the 1 Hz tick into the
// buzzer drive, with ring timeout, 1 s on / 1 s off cadence and a bounded
// number of snoozes per alarm event.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : alarm_sequencer_if.slave (tick, match, alarm_on, snooze, day in;
//          buzz, ringing, snoozing, snooze_left out, all registered)
// Build option: define ALARM_WEEKEND_MUTE_EN to suppress new rings on
// Saturday/Sunday; otherwise day is ignored.
module alarm_sequencer
  import alarm_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 540,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic              clk,
  input  logic              rst,
  alarm_sequencer_if.slave  bus
);

  localparam int SL_W    = $clog2(MAX_SNOOZE + 1);
  localparam int SEC_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int SEC_W   = $clog2(SEC_MAX);

  localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_SECS - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SECS - 1);
  localparam logic [SL_W-1:0]  SL_FULL     = SL_W'(MAX_SNOOZE);

  alarm_state_t     r_state;
  logic [SEC_W-1:0] r_sec_cnt;
  logic             r_phase;
  logic             r_buzz;
  logic             r_ringing;
  logic             r_snoozing;
  logic [SL_W-1:0]  r_snooze_left;

  logic w_match_rise;
  logic w_snooze_rise;
  logic w_muted;

  rise_det u_match_rd (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.match),
    .rise (w_match_rise)
  );

  rise_det u_snooze_rd (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.snooze),
    .rise (w_snooze_rise)
  );

`ifdef ALARM_WEEKEND_MUTE_EN
  assign w_muted = (bus.day == DAY_SAT) | (bus.day == DAY_SUN);
`else
  assign w_muted = 1'b0;
`endif

  // Outputs are written alongside every state change so that buzz, ringing
  // and snoozing always reflect the state being entered on this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_sec_cnt     <= '0;
      r_phase       <= 1'b0;
      r_buzz        <= 1'b0;
      r_ringing     <= 1'b0;
      r_snoozing    <= 1'b0;
      r_snooze_left <= SL_FULL;
    end else if (!bus.alarm_on) begin
      // Disarming overrides every other event, in every state.
      r_state       <= IDLE;
      r_sec_cnt     <= '0;
      r_phase       <= 1'b0;
      r_buzz        <= 1'b0;
      r_ringing     <= 1'b0;
      r_snoozing    <= 1'b0;
      r_snooze_left <= SL_FULL;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_match_rise && !w_muted) begin
            r_state       <= RING;
            r_sec_cnt     <= '0;
            r_phase       <= 1'b1;
            r_buzz        <= 1'b1;
            r_ringing     <= 1'b1;
            r_snooze_left <= SL_FULL;
          end
        end
        RING: begin
          // Snooze is checked first so it beats a coincident timeout tick.
          if (w_snooze_rise && (r_snooze_left != '0)) begin
            r_state       <= SNOOZE;
            r_sec_cnt     <= '0;
            r_phase       <= 1'b0;
            r_buzz        <= 1'b0;
            r_ringing     <= 1'b0;
            r_snoozing    <= 1'b1;
            r_snooze_left <= r_snooze_left - 1'b1;
          end else if (bus.tick) begin
            if (r_sec_cnt == RING_LAST) begin
              r_state   <= IDLE;
              r_sec_cnt <= '0;
              r_phase   <= 1'b0;
              r_buzz    <= 1'b0;
              r_ringing <= 1'b0;
            end else begin
              r_sec_cnt <= r_sec_cnt + 1'b1;
              r_phase   <= ~r_phase;
              r_buzz    <= ~r_phase;
            end
          end
        end
        SNOOZE: begin
          if (bus.tick) begin
            if (r_sec_cnt == SNOOZE_LAST) begin
              r_state    <= RING;
              r_sec_cnt  <= '0;
              r_phase    <= 1'b1;
              r_buzz     <= 1'b1;
              r_ringing  <= 1'b1;
              r_snoozing <= 1'b0;
            end else begin
              r_sec_cnt <= r_sec_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state    <= IDLE;
          r_sec_cnt  <= '0;
          r_phase    <= 1'b0;
          r_buzz     <= 1'b0;
          r_ringing  <= 1'b0;
          r_snoozing <= 1'b0;
        end
      endcase
    end
  end

  assign bus.buzz        = r_buzz;
  assign bus.ringing     = r_ringing;
  assign bus.snoozing    = r_snoozing;
  assign bus.snooze_left = r_snooze_left;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Directed bench for alarm_sequencer with RING_SECS=4, SNOOZE_SECS=3,
// MAX_SNOOZE=2. A vector table covers ring cadence, timeout, snoozing and
// disarm; hand-written sequences cover async reset and the weekend option.
module tb_alarm_sequencer;

  localparam int RS = 4;
  localparam int SS = 3;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  alarm_sequencer_if #(.MAX_SNOOZE(MS)) bus ();

  alarm_sequencer #(
    .RING_SECS   (RS),
    .SNOOZE_SECS (SS),
    .MAX_SNOOZE  (MS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic tick;
    logic match;
    logic aon;
    logic snz;
    logic b;
    logic r;
    logic s;
    int   left;
  } vec_t;

  vec_t vt[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(input logic t, m, a, s, b, r, sn, input int l);
    vec_t v;
    v.tick = t; v.match = m; v.aon = a; v.snz = s;
    v.b = b; v.r = r; v.s = sn; v.left = l;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input logic t, m, a, s, input logic [2:0] d);
    bus.tick = t; bus.match = m; bus.alarm_on = a; bus.snooze = s; bus.day = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int b, r, s, l);
    chk({tag, ".buzz"},        int'(bus.buzz),        b);
    chk({tag, ".ringing"},     int'(bus.ringing),     r);
    chk({tag, ".snoozing"},    int'(bus.snoozing),    s);
    chk({tag, ".snooze_left"}, int'(bus.snooze_left), l);
  endtask

  // Arms the alarm, presents a match edge on the given day and reports
  // whether a ring started; disarms afterwards to return to IDLE.
  task automatic ring_try(input logic [2:0] d, input int exp_ring);
    step(1'b0, 1'b0, 1'b1, 1'b0, d);
    step(1'b0, 1'b1, 1'b1, 1'b0, d);
    chk($sformatf("day%0d.ringing", d), int'(bus.ringing), exp_ring);
    step(1'b0, 1'b0, 1'b0, 1'b0, d);
  endtask

  initial begin
    // tick, match, alarm_on, snooze | buzz, ringing, snoozing, snooze_left
    vt.push_back(mk(0,0,1,0, 0,0,0,2));  // 0  idle
    vt.push_back(mk(0,1,1,0, 1,1,0,2));  // 1  match rise -> ring
    vt.push_back(mk(0,1,1,0, 1,1,0,2));  // 2
    vt.push_back(mk(1,1,1,0, 0,1,0,2));  // 3  tick1
    vt.push_back(mk(0,1,1,0, 0,1,0,2));  // 4
    vt.push_back(mk(1,1,1,0, 1,1,0,2));  // 5  tick2
    vt.push_back(mk(1,1,1,0, 0,1,0,2));  // 6  tick3
    vt.push_back(mk(1,1,1,0, 0,0,0,2));  // 7  tick4 timeout
    vt.push_back(mk(0,1,1,0, 0,0,0,2));  // 8  match held: no re-ring
    vt.push_back(mk(0,0,1,0, 0,0,0,2));  // 9
    vt.push_back(mk(0,1,1,0, 1,1,0,2));  // 10 ring
    vt.push_back(mk(0,1,1,1, 0,0,1,1));  // 11 snooze
    vt.push_back(mk(1,0,1,1, 0,0,1,1));  // 12
    vt.push_back(mk(1,0,1,0, 0,0,1,1));  // 13
    vt.push_back(mk(1,0,1,0, 1,1,0,1));  // 14 back to ring
    vt.push_back(mk(0,0,1,1, 0,0,1,0));  // 15 second snooze
    vt.push_back(mk(1,0,1,0, 0,0,1,0));  // 16
    vt.push_back(mk(1,0,1,0, 0,0,1,0));  // 17
    vt.push_back(mk(1,0,1,0, 1,1,0,0));  // 18 ring again
    vt.push_back(mk(0,1,1,1, 1,1,0,0));  // 19 third snooze + match rise ignored
    vt.push_back(mk(1,0,1,0, 0,1,0,0));  // 20
    vt.push_back(mk(1,0,1,0, 1,1,0,0));  // 21
    vt.push_back(mk(1,0,1,0, 0,1,0,0));  // 22
    vt.push_back(mk(1,0,1,0, 0,0,0,0));  // 23 timeout, count held
    vt.push_back(mk(0,1,1,0, 1,1,0,2));  // 24 new event refills snoozes
    vt.push_back(mk(1,1,1,0, 0,1,0,2));  // 25
    vt.push_back(mk(1,1,1,0, 1,1,0,2));  // 26
    vt.push_back(mk(1,1,1,0, 0,1,0,2));  // 27
    vt.push_back(mk(1,1,1,1, 0,0,1,1));  // 28 snooze beats timeout tick
    vt.push_back(mk(1,1,1,1, 0,0,1,1));  // 29
    vt.push_back(mk(0,1,0,0, 0,0,0,2));  // 30 disarm mid-snooze
    vt.push_back(mk(0,1,1,0, 0,0,0,2));  // 31 rearm with match held: no ring
    vt.push_back(mk(0,0,1,0, 0,0,0,2));  // 32

    bus.tick = 1'b0; bus.match = 1'b0; bus.alarm_on = 1'b0;
    bus.snooze = 1'b0; bus.day = 3'd0;

    #12;
    chk_all("reset", 0, 0, 0, 2);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].tick, vt[i].match, vt[i].aon, vt[i].snz, 3'd0);
      chk_all($sformatf("v%0d", i), int'(vt[i].b), int'(vt[i].r), int'(vt[i].s), vt[i].left);
    end

    // Async reset while ringing with one snooze used.
    step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
    for (int k = 0; k < SS; k++) step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    chk_all("pre_rst", 1, 1, 0, 1);
    rst = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 2);
    bus.match = 1'b0;
    bus.tick  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst", 0, 0, 0, 2);

    // Weekend mute option.
    ring_try(3'd4, 1);
`ifdef ALARM_WEEKEND_MUTE_EN
    ring_try(3'd5, 0);
    ring_try(3'd6, 0);
`else
    ring_try(3'd5, 1);
    ring_try(3'd6, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
